rv32m_divider: RTL and testbench

Iterative RV32M divide unit (DIV, DIVU, REM, REMU) in the EX stage, alongside the single-cycle ALU. The ALU covers add/sub, logic and shifts. This block covers the divide side, which needs a multi-cycle, shift-subtract datapath. Uses a start/busy/done handshake with the hazard unit, which stalls the pipeline while busy=1. Flush input supports branch mispredict.

---
 rtl/rv32m_pkg.sv | 19 +
 rtl/rv32m_divider_div_step.sv | 30 +++
 rtl/rv32m_divider.sv | 115 +++++++++++
 tb/tb_rv32m_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide unit: op codes, op width, FSM states.
package rv32m_pkg;

  localparam int unsigned OP_W = 2;

  // funct3[1:0] encodings of the divide instructions
  localparam logic [OP_W-1:0] OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/rv32m_divider_div_step.sv
// One combinational restoring-division step on magnitudes.
// The pair {r,q} shifts left by one. The shifted-in partial remainder is then compared
// against the divisor d using an (n+1)-bit trial subtraction.
module div_step #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] r,
  input  logic [n-1:0] q,
  input  logic [n-1:0] d,
  output logic [n-1:0] r_next,
  output logic [n-1:0] q_next
);

  logic [n:0] r_shift;
  logic [n:0] trial;

  // Shift, trial-subtract, and restore when the trial goes negative
  always_comb begin
    r_shift = {r, q[n-1]};
    trial   = r_shift - {1'b0, d};
    if (!trial[n]) begin
      r_next = trial[n-1:0];
      q_next = {q[n-2:0], 1'b1};
    end else begin
      r_next = r_shift[n-1:0];
      q_next = {q[n-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32m_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with a start/busy/done handshake.
// Divide-by-zero and signed overflow finish in one cycle. All other operations take
// n restoring steps plus one sign-fix cycle.
module rv32m_divider
  import rv32m_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [n-1:0]    a,
  input  logic [n-1:0]    b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [n-1:0]    result
);

  localparam int unsigned CNT_W = $clog2(n);

  state_t          state, state_nx;
  logic [CNT_W-1:0] count;
  logic [OP_W-1:0] op_q;
  logic [n-1:0]    rem_q, quo_q, bmag_q;
  logic            sign_a_q, sign_b_q;

  logic            accept, in_signed, in_rem, b_zero, ovf, special;
  logic            sign_a_in, sign_b_in, q_rem;
  logic [n-1:0]    rem_step, quo_step;

  // Decode the incoming request and its special cases
  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    in_signed = (op == OP_DIV) || (op == OP_REM);
    in_rem    = (op == OP_REM) || (op == OP_REMU);
    b_zero    = (b == '0);
    ovf       = in_signed && (a == {1'b1, {(n-1){1'b0}}}) && (b == '1);
    special   = b_zero || ovf;
    sign_a_in = in_signed && a[n-1];
    sign_b_in = in_signed && b[n-1];
    q_rem     = (op_q == OP_REM) || (op_q == OP_REMU);
  end

  div_step #(.n(n)) u_step (
    .r      (rem_q),
    .q      (quo_q),
    .d      (bmag_q),
    .r_next (rem_step),
    .q_next (quo_step)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    unique case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: begin
        if (flush)                           state_nx = IDLE;
        else if (count == CNT_W'(n - 1))     state_nx = FIX;
      end
      FIX:  state_nx = flush ? IDLE : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result   <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q     <= op;
          sign_a_q <= sign_a_in;
          sign_b_q <= sign_b_in;
          count    <= '0;
          rem_q    <= '0;
          quo_q    <= sign_a_in ? -a : a;
          bmag_q   <= sign_b_in ? -b : b;
          if (b_zero)   result <= in_rem ? a : '1;
          else if (ovf) result <= in_rem ? '0 : a;
        end
        CALC: if (!flush) begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          count <= count + 1'b1;
        end
        FIX: if (!flush) begin
          if (q_rem) result <= sign_a_q ? -rem_q : rem_q;
          else       result <= (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed self-checking bench for rv32m_divider.
module tb_rv32m_divider;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  rv32m_divider #(.n(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done. lat counts edges from the accept edge
  // (1) to the edge that raised done. Then step past the DONE cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output bit tmo);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo = (done !== 1'b1);
    res = result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat; bit tmo;
    do_op(OP_DIVU, 32'd100, 32'd7, r, lat, tmo);
    tests++; if (tmo || r !== 32'd14) begin fails++; $display("FAIL divu_100_7 got %h want %h tmo=%0d", r, 32'd14, tmo); end
    tests++; if (lat !== 34) begin fails++; $display("FAIL divu_latency got %0d want 34", lat); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done got %b want 0", busy); end
    do_op(OP_REMU, 32'd100, 32'd7, r, lat, tmo);
    tests++; if (tmo || r !== 32'd2) begin fails++; $display("FAIL remu_100_7 got %h want %h", r, 32'd2); end
    do_op(OP_DIVU, 32'hFFFFFFFF, 32'd2, r, lat, tmo);
    tests++; if (tmo || r !== 32'h7FFFFFFF) begin fails++; $display("FAIL divu_max_2 got %h want 7fffffff", r); end
    do_op(OP_REMU, 32'd7, 32'd100, r, lat, tmo);
    tests++; if (tmo || r !== 32'd7) begin fails++; $display("FAIL remu_7_100 got %h want 7", r); end
    // Signed-overflow operands are an ordinary unsigned divide: 0x80000000 / 0xFFFFFFFF = 0
    do_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, r, lat, tmo);
    tests++; if (tmo || r !== 32'h0 || lat !== 34) begin fails++; $display("FAIL divu_ovf_ops got %h lat %0d want 0 lat 34", r, lat); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat; bit tmo;
    do_op(OP_DIV, 32'hFFFFFF9C, 32'd7, r, lat, tmo);
    tests++; if (tmo || r !== 32'hFFFFFFF2) begin fails++; $display("FAIL div_m100_7 got %h want fffffff2", r); end
    tests++; if (lat !== 34) begin fails++; $display("FAIL div_latency got %0d want 34", lat); end
    do_op(OP_REM, 32'hFFFFFF9C, 32'd7, r, lat, tmo);
    tests++; if (tmo || r !== 32'hFFFFFFFE) begin fails++; $display("FAIL rem_m100_7 got %h want fffffffe", r); end
    do_op(OP_DIV, 32'd100, 32'hFFFFFFF9, r, lat, tmo);
    tests++; if (tmo || r !== 32'hFFFFFFF2) begin fails++; $display("FAIL div_100_m7 got %h want fffffff2", r); end
    do_op(OP_REM, 32'd100, 32'hFFFFFFF9, r, lat, tmo);
    tests++; if (tmo || r !== 32'd2) begin fails++; $display("FAIL rem_100_m7 got %h want 2", r); end
    do_op(OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, r, lat, tmo);
    tests++; if (tmo || r !== 32'd14) begin fails++; $display("FAIL div_m100_m7 got %h want e", r); end
    do_op(OP_DIV, 32'h80000000, 32'd2, r, lat, tmo);
    tests++; if (tmo || r !== 32'hC0000000) begin fails++; $display("FAIL div_min_2 got %h want c0000000", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int lat; bit tmo;
    do_op(OP_DIV, 32'd5, 32'd0, r, lat, tmo);
    tests++; if (tmo || r !== 32'hFFFFFFFF || lat !== 1) begin fails++; $display("FAIL div_by_zero got %h lat %0d want ffffffff lat 1", r, lat); end
    do_op(OP_REM, 32'd5, 32'd0, r, lat, tmo);
    tests++; if (tmo || r !== 32'd5 || lat !== 1) begin fails++; $display("FAIL rem_by_zero got %h lat %0d want 5 lat 1", r, lat); end
    do_op(OP_REMU, 32'hFFFFFF9C, 32'd0, r, lat, tmo);
    tests++; if (tmo || r !== 32'hFFFFFF9C || lat !== 1) begin fails++; $display("FAIL remu_by_zero got %h lat %0d want ffffff9c lat 1", r, lat); end
    do_op(OP_DIVU, 32'd9, 32'd0, r, lat, tmo);
    tests++; if (tmo || r !== 32'hFFFFFFFF || lat !== 1) begin fails++; $display("FAIL divu_by_zero got %h lat %0d want ffffffff lat 1", r, lat); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int lat; bit tmo;
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, tmo);
    tests++; if (tmo || r !== 32'h80000000 || lat !== 1) begin fails++; $display("FAIL div_overflow got %h lat %0d want 80000000 lat 1", r, lat); end
    do_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, r, lat, tmo);
    tests++; if (tmo || r !== 32'h0 || lat !== 1) begin fails++; $display("FAIL rem_overflow got %h lat %0d want 0 lat 1", r, lat); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; bit tmo; int pulses;
    do_op(OP_DIVU, 32'd100, 32'd7, r, lat, tmo);
    // Start a long divide and flush it in its 10th CALC cycle
    @(negedge clk);
    op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", busy); end
    pulses = 0;
    repeat (40) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", pulses); end
    tests++; if (result !== 32'd14) begin fails++; $display("FAIL flush_result_held got %h want e", result); end
    // start together with flush in IDLE is not accepted
    @(negedge clk); op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_blocks_start got busy %b want 0", busy); end
    do_op(OP_DIV, 32'd1000, 32'd3, r, lat, tmo);
    tests++; if (tmo || r !== 32'd333 || lat !== 34) begin fails++; $display("FAIL after_flush got %h lat %0d want 14d lat 34", r, lat); end
  endtask

  task automatic test_async_reset();
    int pulses;
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL async_reset_ctrl got busy %b done %b want 0 0", busy, done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL async_reset_result got %h want 0", result); end
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL async_reset_abandon got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] r; bit tmo;
    // Hold start high with different operands through the whole operation, DONE included
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    op = OP_DIV; a = 32'd50; b = 32'd5;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (done !== 1'b1 || result !== 32'd14 || lat !== 34) begin fails++; $display("FAIL busy_ignore got %h lat %0d want e lat 34", result, lat); end
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_in_done got busy %b want 0", busy); end
    // Accept immediately in the first idle cycle
    do_op(OP_REM, 32'hFFFFFFCE, 32'd5, r, lat, tmo);
    tests++; if (tmo || r !== 32'h0 || lat !== 34) begin fails++; $display("FAIL back_to_back got %h lat %0d want 0 lat 34", r, lat); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
